// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control stage.
// Lap support is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int CLK_HZ_DEF      = 50_000_000;
  localparam int TICK_HZ_DEF     = 1000;
  localparam int DEBOUNCE_MS_DEF = 20;

  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_LAP = 2;

endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchronizer plus tick-based debouncer for one active-low button.
// Emits a one-cycle press strobe on the debounced 1->0 edge.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      // Accept the new level on the tick that completes the stable window.
      if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_q & ~level_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ms prescaler, button debouncers and start/stop/clear FSM for the timer.
// Define STOPWATCH_LAP_EN to add the lap button and freeze output.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int TICK_HZ     = TICK_HZ_DEF,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_n,
  output logic       ms_tick,
  output logic       run,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0] pre_q, pre_d;
  sw_state_t     state_q, state_d;
  logic          run_q;
  logic          clr_q, clr_d;
  logic          ss_p, clr_p;
  logic          ss_lvl_unused, clr_lvl_unused;

  assign ms_tick = (pre_q == PW'(DIV - 1));
  assign pre_d   = ms_tick ? '0 : pre_q + PW'(1);

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (ms_tick),
    .raw_n (btn_n[BTN_SS]),
    .level (ss_lvl_unused),
    .press (ss_p)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (ms_tick),
    .raw_n (btn_n[BTN_CLR]),
    .level (clr_lvl_unused),
    .press (clr_p)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_p, lap_lvl_unused;
  logic freeze_q, freeze_d;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_lap (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (ms_tick),
    .raw_n (btn_n[BTN_LAP]),
    .level (lap_lvl_unused),
    .press (lap_p)
  );

  always_comb begin
    freeze_d = freeze_q;
    if (state_q == RUN && lap_p) freeze_d = ~freeze_q;
    if (state_d == IDLE) freeze_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) freeze_q <= 1'b0;
    else        freeze_q <= freeze_d;
  end

  assign freeze = freeze_q;
`else
  logic lap_unused;
  assign lap_unused = btn_n[BTN_LAP];
  assign freeze     = 1'b0;
`endif

  // Clear outranks start/stop except in RUN, where clear is ignored.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_p)     clr_d   = 1'b1;
        else if (ss_p) state_d = RUN;
      end
      RUN: begin
        if (ss_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_p) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      state_q <= IDLE;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      run_q   <= (state_d == RUN);
      clr_q   <= clr_d;
    end
  end

  assign run   = run_q;
  assign clr   = clr_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a press-level behavioural model.
// Uses CLK_HZ=1000, TICK_HZ=100, DEBOUNCE_MS=3 (DIV=10).
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic       ms_tick, run, clr, freeze;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ      (1000),
    .TICK_HZ     (100),
    .DEBOUNCE_MS (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_n   (btn_n),
    .ms_tick (ms_tick),
    .run     (run),
    .clr     (clr),
    .freeze  (freeze),
    .state   (state)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: abstract stopwatch state, freeze flag, cycles since reset.
  int m_st = 0;
  bit m_fz = 1'b0;
  int since_rst = 0;
  bit mon_on = 1'b0;
  int clr_hi = 0;
  int clr_rise = 0;
  bit clr_prev = 1'b0;

  always @(posedge clk) since_rst <= rst_n ? since_rst + 1 : 0;

  always @(negedge clk) begin
    if (mon_on) begin
      chk("ms_tick", ms_tick, (since_rst % 10) == 9);
      if (clr === 1'b1) clr_hi++;
      if (clr === 1'b1 && !clr_prev) clr_rise++;
      clr_prev = (clr === 1'b1);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(string tag);
    chk({tag, "_state"}, state, m_st);
    chk({tag, "_run"}, run, m_st == 1);
    chk({tag, "_freeze"}, freeze, m_fz);
  endtask

  task automatic press(logic [2:0] mask, bit bounce, string tag);
    int lat, prev_st, ch0, cr0, nst;
    bit ss, cl, lp, pulse;
    ss = mask[0];
    cl = mask[1];
    lp = mask[2];
    ch0 = clr_hi;
    cr0 = clr_rise;
    if (bounce) begin
      repeat ($urandom_range(4, 1)) begin
        btn_n = ~mask;
        cyc($urandom_range(3, 1));
        btn_n = 3'b111;
        cyc($urandom_range(3, 1));
      end
    end
    btn_n = ~mask;
    prev_st = state;
    lat = -1;
    for (int i = 0; i < 45; i++) begin
      cyc(1);
      if (lat < 0 && state !== prev_st[1:0]) lat = i + 1;
    end
    btn_n = 3'b111;
    cyc(45);
    nst = m_st;
    pulse = 1'b0;
    case (m_st)
      0: if (cl) pulse = 1'b1; else if (ss) nst = 1;
      1: begin
        if (ss) nst = 2;
        if (lp && LAP) m_fz = !m_fz;
      end
      default: begin
        if (cl) begin
          nst = 0;
          pulse = 1'b1;
        end else if (ss) begin
          nst = 1;
        end
      end
    endcase
    if (nst == 0) m_fz = 1'b0;
    if (nst != m_st) chk({tag, "_latency_ok"}, lat >= 1 && lat <= 42, 1);
    m_st = nst;
    check_outs(tag);
    chk({tag, "_clr_cycles"}, clr_hi - ch0, pulse);
    chk({tag, "_clr_pulses"}, clr_rise - cr0, pulse);
  endtask

  task automatic mid_reset(string tag);
    rst_n = 1'b0;
    cyc(1);
    m_st = 0;
    m_fz = 1'b0;
    check_outs(tag);
    chk({tag, "_clr"}, clr, 0);
    chk({tag, "_tick"}, ms_tick, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int ch0, r;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_state", state, 0);
    chk("rst_run", run, 0);
    chk("rst_clr", clr, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_tick", ms_tick, 0);
    mon_on = 1'b1;
    rst_n = 1'b1;
    cyc(5);

    ch0 = clr_hi;
    for (int i = 0; i < 20; i++) begin
      btn_n[0] = ~btn_n[0];
      cyc(4);
    end
    btn_n = 3'b111;
    cyc(45);
    chk("bounce_state", state, 0);
    chk("bounce_clr", clr_hi - ch0, 0);

    press(3'b001, 1'b0, "start");
    press(3'b010, 1'b0, "clr_in_run");
    press(3'b100, 1'b0, "lap1");
    press(3'b100, 1'b0, "lap2");
    press(3'b100, 1'b1, "lap3");
    press(3'b001, 1'b0, "stop");
    press(3'b100, 1'b0, "lap_pause");
    press(3'b010, 1'b0, "clr_pause");
    press(3'b001, 1'b1, "start2");
    press(3'b001, 1'b0, "stop2");
    press(3'b011, 1'b0, "both_pause");
    press(3'b001, 1'b0, "start3");
    press(3'b011, 1'b0, "both_run");
    press(3'b001, 1'b0, "start4");
    chk("pre_reset_run", run, 1);
    mid_reset("mid_reset");
    cyc(5);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(9, 0);
      case (r)
        0, 1, 2, 3: press(3'b001, 1'($urandom_range(1, 0)), "rnd_ss");
        4: press(3'b010, 1'($urandom_range(1, 0)), "rnd_clr");
        5: press(3'b011, 1'($urandom_range(1, 0)), "rnd_both");
        6, 7: press(3'b100, 1'($urandom_range(1, 0)), "rnd_lap");
        8: press(3'b101, 1'($urandom_range(1, 0)), "rnd_lap_ss");
        default: begin
          mid_reset("rnd_reset");
          cyc(3);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end control stage for the DE0 LED decade timer. It divides the 50 MHz board clock into a 1 ms tick, synchronizes and debounces the raw active-low pushbuttons, and runs a start/stop/clear state machine. Its outputs drive the timer's count enable (`run`) and synchronous clear (`clr`) directly, and share the ms tick so the timer needs no prescaler of its own.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 1000: tick rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `DEBOUNCE_MS`, default 20: consecutive ticks of stable input needed to accept a change; must be ≥ 1.
- `clk` input, 1 bit: board clock; all logic on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `btn_n` input, 3 bits: raw asynchronous buttons, active-low.
  - [0] start/stop
  - [1] clear
  - [2] lap, used only with `STOPWATCH_LAP_EN`
- `ms_tick` output, 1 bit: one-cycle pulse every `DIV` clocks.
- `run` output, 1 bit: count enable to the timer; high in RUN.
- `clr` output, 1 bit: one-cycle clear pulse to the timer.
- `freeze` output, 1 bit: display hold (lap). Constant 0 when the feature is compiled out.
- `state` output, 2 bits: FSM state, for debug LEDs.

## Operation
- **Prescaler**
  - Counter width is `$clog2(DIV)`. It counts 0..DIV-1 and wraps to 0.
  - `ms_tick` is high in the cycle where count = DIV-1.
- **Per-button path**
  - Synchronizer: 2-FF, reset value 1 (released).
  - Debounced level reset value: 1.
  - Debounce counter, width `$clog2(DEBOUNCE_MS+1)`:
    - Cleared whenever the synced input equals the debounced level.
    - Otherwise increments on each `ms_tick`.
    - On reaching `DEBOUNCE_MS`, the debounced level takes the synced value and the counter clears.
  - Press strobe: one cycle when the debounced level goes 1→0. Release produces no strobe.
- **FSM states:** IDLE=0, RUN=1, PAUSE=2. Encoding 3 is illegal and recovers to IDLE on the next clock.
  - IDLE: start/stop → RUN. Clear → stay IDLE and pulse `clr`.
  - RUN: start/stop → PAUSE. Clear is ignored.
  - PAUSE: start/stop → RUN. Clear → IDLE and pulse `clr`.
- **Simultaneous start/stop and clear strobes**
  - In IDLE or PAUSE, clear wins: go to IDLE and pulse `clr`.
  - In RUN, start/stop wins: go to PAUSE; clear is dropped.
- **Outputs:** `run` and `clr` are registered, updated in the same edge as `state`.
- **Held buttons:** a button held through reset release registers as a press once it has been debounced.

## Timing
- **Reset:** on the first rising edge with `rst_n`=0:
  - `state`=IDLE, `run`=0, `clr`=0, `freeze`=0, `ms_tick`=0.
  - Prescaler and debounce counters = 0.
  - Synchronizers and debounced levels = 1.
- **Reset mid-operation:** any state returns to IDLE on that edge. `clr` is not pulsed; the timer is expected to share `rst_n`.
- **Press-to-action latency:** for an input held stable from cycle t, the press strobe fires after 2 synchronizer cycles plus `DEBOUNCE_MS` ticks. That is at most `2 + DEBOUNCE_MS*DIV + DIV` cycles.
- **Strobe to outputs:** the press strobe is combinational into the FSM. `state`, `run` and `clr` change on the edge after the strobe cycle.
- **Pulse widths:**
  - `clr` is exactly 1 cycle.
  - At most one strobe per button per debounced press.
- **Bounce rejection:** input glitches shorter than one tick period never advance the debounce counter past 1 tick.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- **Defined:**
  - `btn_n[2]` is debounced.
  - A lap strobe in RUN toggles `freeze`. A lap strobe in IDLE or PAUSE is ignored.
  - Entering IDLE, by clear or reset, forces `freeze`=0. PAUSE holds `freeze` at its current value.
- **Undefined:**
  - `btn_n[2]` is ignored, and no synchronizer or debouncer is built for it.
  - `freeze` is tied to 0.

## Structure
- Package `stopwatch_pkg`:
  - State typedef `sw_state_t` (IDLE/RUN/PAUSE).
  - Default constants for `CLK_HZ`, `TICK_HZ` and `DEBOUNCE_MS`.
  - Button index constants: `BTN_SS`=0, `BTN_CLR`=1, `BTN_LAP`=2.
- Sub-module `btn_debounce`, parameter `DEBOUNCE_MS`.
  - Inputs: `clk`, `rst_n`, `tick`, `raw_n`.
  - Outputs: `level`, `press`.
  - Instantiated once per button in use.
- The prescaler and FSM stay in the top module.

## Test plan
All scenarios use `CLK_HZ`=1000, `TICK_HZ`=100 (so `DIV`=10) and `DEBOUNCE_MS`=3.
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0 and `state`=0. After release, `ms_tick` pulses at cycles 9, 19, 29, …
- **Clean start/stop:** `btn_n[0]`=0 held 60 cycles → `run` rises within ≤42 cycles, and `state`=1. Release, then a second 60-cycle press → `run`=0 and `state`=2.
- **Bounce:** toggle `btn_n[0]` every 4 cycles for 80 cycles, then release → no strobe; `state` stays IDLE.
- **Clear:**
  - In PAUSE, press `btn_n[1]` → exactly one `clr` cycle, and `state`=0.
  - In RUN, press `btn_n[1]` → no `clr`; `run` stays 1.
- **Simultaneous presses:**
  - Press `btn_n[1:0]` together in PAUSE → `clr` pulse and IDLE.
  - Press both together in RUN → PAUSE with no `clr`.
- **Reset mid-RUN:** drop `rst_n` while `run`=1 → next edge gives `state`=0 and `run`=0.
- **Lap (`STOPWATCH_LAP_EN` defined):**
  - Press lap in RUN → `freeze`=1; press again → 0.
  - Press lap in PAUSE → `freeze` unchanged.
  - Clear from PAUSE → `freeze`=0.
